// File: rtl/msrv32_store_unit_if.sv
// rtl/msrv32_store_unit_if.sv - core request and AHB write bus bundle for the store unit
interface msrv32_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              store_req_in;
  logic [1:0]        store_size_in;
  logic [ADDR_W-1:0] iadder_in;
  logic [ADDR_W-1:0] rs2_in;
  logic              ahb_ready_in;
  logic              ahb_resp_in;
  logic [ADDR_W-1:0] dmaddr_out;
  logic [ADDR_W-1:0] dmdata_out;
  logic [3:0]        dmwr_mask_out;
  logic              dmwr_req_out;
  logic [1:0]        htrans_out;
  logic              busy_out;
  logic              done_out;
  logic              store_err_out;
  logic              misaligned_out;

  // The store unit masters the data bus; the core/bus environment is the slave side.
  modport master (
    input  store_req_in, store_size_in, iadder_in, rs2_in, ahb_ready_in, ahb_resp_in,
    output dmaddr_out, dmdata_out, dmwr_mask_out, dmwr_req_out, htrans_out,
           busy_out, done_out, store_err_out, misaligned_out
  );

  modport slave (
    output store_req_in, store_size_in, iadder_in, rs2_in, ahb_ready_in, ahb_resp_in,
    input  dmaddr_out, dmdata_out, dmwr_mask_out, dmwr_req_out, htrans_out,
           busy_out, done_out, store_err_out, misaligned_out
  );
endinterface

// File: rtl/msrv32_store_unit.sv
// rtl/msrv32_store_unit.sv - single-outstanding AHB store unit with lane replication and alignment check
module msrv32_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  msrv32_store_unit_if.master bus
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t            state;
  logic              misaligned;
  logic [ADDR_W-1:0] wdata;
  logic [3:0]        wmask;

  always_comb begin
    misaligned = 1'b0;
    wdata      = bus.rs2_in;
    wmask      = 4'b1111;
    case (bus.store_size_in)
      2'b00: begin
        wdata = {4{bus.rs2_in[7:0]}};
        wmask = 4'b0001 << bus.iadder_in[1:0];
      end
      2'b01: begin
        misaligned = bus.iadder_in[0];
        wdata      = {2{bus.rs2_in[15:0]}};
        wmask      = 4'b0011 << {bus.iadder_in[1], 1'b0};
      end
      default: begin
        misaligned = (bus.iadder_in[1:0] != 2'b00);
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state              <= IDLE;
      bus.dmaddr_out     <= '0;
      bus.dmdata_out     <= '0;
      bus.dmwr_mask_out  <= '0;
      bus.dmwr_req_out   <= 1'b0;
      bus.htrans_out     <= 2'b00;
      bus.busy_out       <= 1'b0;
      bus.done_out       <= 1'b0;
      bus.store_err_out  <= 1'b0;
      bus.misaligned_out <= 1'b0;
    end else begin
      // Completion/reject indications are single-cycle pulses.
      bus.done_out       <= 1'b0;
      bus.store_err_out  <= 1'b0;
      bus.misaligned_out <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.store_req_in) begin
            if (misaligned) begin
              bus.misaligned_out <= 1'b1;
            end else begin
              state             <= ADDR;
              bus.dmaddr_out    <= {bus.iadder_in[ADDR_W-1:2], 2'b00};
              bus.dmdata_out    <= wdata;
              bus.dmwr_mask_out <= wmask;
              bus.dmwr_req_out  <= 1'b1;
              bus.htrans_out    <= 2'b10;
              bus.busy_out      <= 1'b1;
            end
          end
        end
        ADDR: begin
          if (bus.ahb_ready_in) begin
            state            <= DATA;
            bus.dmwr_req_out <= 1'b0;
            bus.htrans_out   <= 2'b00;
          end
        end
        DATA: begin
          // HRESP only matters on the completing data-phase edge.
          if (bus.ahb_ready_in) begin
            state             <= IDLE;
            bus.busy_out      <= 1'b0;
            bus.dmdata_out    <= '0;
            bus.dmwr_mask_out <= '0;
            if (bus.ahb_resp_in) bus.store_err_out <= 1'b1;
            else                 bus.done_out      <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_msrv32_store_unit.sv
// tb/tb_msrv32_store_unit.sv - vector table, reset and randomized checks for msrv32_store_unit
module tb_msrv32_store_unit;
  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_in = ~clk_in;

  msrv32_store_unit_if #(.ADDR_W(32)) bus_if ();
  msrv32_store_unit #(.ADDR_W(32)) dut (.clk_in(clk_in), .rst_n_in(rst_n_in), .bus(bus_if));

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] rs2;
    int          aw;
    int          dw;
    logic        resp;
    logic        emis;
    logic [31:0] eaddr;
    logic [31:0] edata;
    logic [3:0]  emask;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string nm, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m, input logic wr, input logic [1:0] ht,
                          input logic busy, input logic done, input logic err, input logic mis);
    chk({nm, ".dmaddr"}, bus_if.dmaddr_out, a);
    chk({nm, ".dmdata"}, bus_if.dmdata_out, d);
    chk({nm, ".mask"}, 32'(bus_if.dmwr_mask_out), 32'(m));
    chk({nm, ".wr_req"}, 32'(bus_if.dmwr_req_out), 32'(wr));
    chk({nm, ".htrans"}, 32'(bus_if.htrans_out), 32'(ht));
    chk({nm, ".busy"}, 32'(bus_if.busy_out), 32'(busy));
    chk({nm, ".done"}, 32'(bus_if.done_out), 32'(done));
    chk({nm, ".err"}, 32'(bus_if.store_err_out), 32'(err));
    chk({nm, ".misaligned"}, 32'(bus_if.misaligned_out), 32'(mis));
  endtask

  // Reference model: byte count from size, alignment by modulo, lanes by multiplication.
  task automatic model(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] rs2,
                       output logic mis, output logic [31:0] ea, output logic [31:0] ed,
                       output logic [3:0] em);
    int unsigned nb;
    int unsigned tmp;
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    mis = (addr % nb) != 0;
    ea  = addr - (addr % 4);
    if (nb == 1)      ed = (rs2 & 32'hFF) * 32'h0101_0101;
    else if (nb == 2) ed = (rs2 & 32'hFFFF) * 32'h0001_0001;
    else              ed = rs2;
    tmp = ((1 << nb) - 1) << (addr % 4);
    em  = tmp[3:0];
  endtask

  // A competing request while busy must have no effect.
  task automatic noise();
    bus_if.store_req_in  = 1'b1;
    bus_if.store_size_in = 2'($urandom_range(0, 3));
    bus_if.iadder_in     = $urandom;
    bus_if.rs2_in        = $urandom;
  endtask

  // Called at a negedge; returns at the negedge on which done/err/misaligned is visible.
  task automatic run_store(input string nm, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] rs2, input int aw, input int dw, input logic resp,
                           input logic emis, input logic [31:0] ea, input logic [31:0] ed,
                           input logic [3:0] em);
    bus_if.store_req_in  = 1'b1;
    bus_if.store_size_in = size;
    bus_if.iadder_in     = addr;
    bus_if.rs2_in        = rs2;
    bus_if.ahb_ready_in  = 1'b0;
    bus_if.ahb_resp_in   = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    if (emis) begin
      bus_if.store_req_in = 1'b0;
      chk({nm, ".mis"}, 32'(bus_if.misaligned_out), 32'd1);
      chk({nm, ".mis_wr"}, 32'(bus_if.dmwr_req_out), 32'd0);
      chk({nm, ".mis_busy"}, 32'(bus_if.busy_out), 32'd0);
      chk({nm, ".mis_mask"}, 32'(bus_if.dmwr_mask_out), 32'd0);
      chk({nm, ".mis_htrans"}, 32'(bus_if.htrans_out), 32'd0);
      chk({nm, ".mis_done"}, 32'(bus_if.done_out | bus_if.store_err_out), 32'd0);
      return;
    end
    noise();
    chk_outs({nm, ".addr"}, ea, ed, em, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < aw; i++) begin
      bus_if.ahb_ready_in = 1'b0;
      bus_if.ahb_resp_in  = 1'($urandom);
      noise();
      @(posedge clk_in);
      @(negedge clk_in);
      chk_outs({nm, ".addr_hold"}, ea, ed, em, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    bus_if.ahb_ready_in = 1'b1;
    bus_if.ahb_resp_in  = 1'($urandom);
    noise();
    @(posedge clk_in);
    @(negedge clk_in);
    chk_outs({nm, ".data"}, ea, ed, em, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < dw; i++) begin
      bus_if.ahb_ready_in = 1'b0;
      bus_if.ahb_resp_in  = 1'($urandom);
      noise();
      @(posedge clk_in);
      @(negedge clk_in);
      chk_outs({nm, ".data_hold"}, ea, ed, em, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    bus_if.ahb_ready_in = 1'b1;
    bus_if.ahb_resp_in  = resp;
    noise();
    @(posedge clk_in);
    @(negedge clk_in);
    bus_if.store_req_in = 1'b0;
    bus_if.ahb_resp_in  = 1'b0;
    chk_outs({nm, ".end"}, ea, 32'd0, 4'd0, 1'b0, 2'b00, 1'b0, ~resp, resp, 1'b0);
  endtask

  initial begin
    logic        mis;
    logic [31:0] ea, ed;
    logic [3:0]  em;
    logic [1:0]  sz;
    logic [31:0] ad, rd;

    bus_if.store_req_in  = 1'b0;
    bus_if.store_size_in = 2'b00;
    bus_if.iadder_in     = 32'd0;
    bus_if.rs2_in        = 32'd0;
    bus_if.ahb_ready_in  = 1'b1;
    bus_if.ahb_resp_in   = 1'b0;

    //         size   addr      rs2           aw dw resp mis eaddr     edata         emask
    vecs[0] = '{2'b00, 32'h1003, 32'h0000_00AB, 0, 0, 0, 0, 32'h1000, 32'hABAB_ABAB, 4'b1000};
    vecs[1] = '{2'b01, 32'h2002, 32'h1234_CDEF, 2, 0, 0, 0, 32'h2000, 32'hCDEF_CDEF, 4'b1100};
    vecs[2] = '{2'b10, 32'h3001, 32'h1111_1111, 0, 0, 0, 1, 32'h0,    32'h0,         4'b0000};
    vecs[3] = '{2'b10, 32'h4000, 32'hDEAD_BEEF, 0, 1, 1, 0, 32'h4000, 32'hDEAD_BEEF, 4'b1111};
    vecs[4] = '{2'b01, 32'h5001, 32'h2222_2222, 0, 0, 0, 1, 32'h0,    32'h0,         4'b0000};
    vecs[5] = '{2'b00, 32'h6000, 32'h1234_5678, 0, 0, 0, 0, 32'h6000, 32'h7878_7878, 4'b0001};
    vecs[6] = '{2'b01, 32'h7000, 32'h0000_BEEF, 1, 2, 0, 0, 32'h7000, 32'hBEEF_BEEF, 4'b0011};
    vecs[7] = '{2'b11, 32'h8002, 32'h3333_3333, 0, 0, 0, 1, 32'h0,    32'h0,         4'b0000};
    vecs[8] = '{2'b00, 32'h9001, 32'h0000_00C3, 3, 1, 0, 0, 32'h9000, 32'hC3C3_C3C3, 4'b0010};
    vecs[9] = '{2'b11, 32'hA004, 32'h0102_0304, 0, 0, 1, 0, 32'hA004, 32'h0102_0304, 4'b1111};

    #12;
    chk_outs("reset", 32'd0, 32'd0, 4'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    @(negedge clk_in);
    rst_n_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      run_store($sformatf("vec%0d", i), vecs[i].size, vecs[i].addr, vecs[i].rs2, vecs[i].aw,
                vecs[i].dw, vecs[i].resp, vecs[i].emis, vecs[i].eaddr, vecs[i].edata, vecs[i].emask);
    end

    // Reset dropped in the data phase abandons the transfer.
    bus_if.store_req_in  = 1'b1;
    bus_if.store_size_in = 2'b10;
    bus_if.iadder_in     = 32'hB000;
    bus_if.rs2_in        = 32'h5555_5555;
    bus_if.ahb_ready_in  = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    bus_if.store_req_in = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    chk("rst.in_data_busy", 32'(bus_if.busy_out), 32'd1);
    chk("rst.in_data_wr", 32'(bus_if.dmwr_req_out), 32'd0);
    rst_n_in = 1'b0;
    #1;
    chk_outs("rst.async", 32'd0, 32'd0, 4'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    chk_outs("rst.held", 32'd0, 32'd0, 4'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n_in = 1'b1;
    run_store("post_rst", 2'b00, 32'hC001, 32'h0000_005A, 0, 0, 1'b0, 1'b0,
              32'hC000, 32'h5A5A_5A5A, 4'b0010);

    for (int i = 0; i < 40; i++) begin
      sz = 2'($urandom_range(0, 3));
      ad = $urandom;
      rd = $urandom;
      if ($urandom_range(0, 1) == 0) ad[1:0] = 2'b00;
      model(sz, ad, rd, mis, ea, ed, em);
      run_store($sformatf("rnd%0d", i), sz, ad, rd, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom), mis, ea, ed, em);
    end

    @(posedge clk_in);
    @(negedge clk_in);
    chk("tail.done", 32'(bus_if.done_out), 32'd0);
    chk("tail.err", 32'(bus_if.store_err_out), 32'd0);
    chk("tail.mis", 32'(bus_if.misaligned_out), 32'd0);
    chk("tail.busy", 32'(bus_if.busy_out), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
